// File: rtl/uart_sample_packer_if.sv
// uart_sample_packer_if -- sample output stream of the UART sample packer.
//
// Carries the first-word-fall-through sample stream:
//   sample_data  [15:0]  assembled signed sample {high byte, low byte}
//   sample_valid         a sample is present; data/last are meaningful
//   sample_ready         consumer accepts; transfer on valid && ready
//   sample_last          sample is the final one of its frame
//
// Modports:
//   master  producer side (the packer drives data/valid/last)
//   slave   consumer side (drives ready)
interface uart_sample_packer_if;
  logic [15:0] sample_data;
  logic        sample_valid;
  logic        sample_ready;
  logic        sample_last;

  modport master (
    output sample_data,
    output sample_valid,
    output sample_last,
    input  sample_ready
  );

  modport slave (
    input  sample_data,
    input  sample_valid,
    input  sample_last,
    output sample_ready
  );
endinterface

// File: rtl/uart_sample_packer.sv
// uart_sample_packer -- packs a UART byte stream into 16-bit samples.
//
// Bytes arrive low byte first. Every pair becomes one sample that is pushed
// into a small first-word-fall-through FIFO, tagged with a last flag on the
// final sample of each FRAME_LEN-sample frame. rx_endofpacket resynchronises
// the byte/sample framing and reports truncated frames.
//
// Parameters:
//   FRAME_LEN   samples per frame (2..65535)
//   FIFO_DEPTH  output FIFO entries (power of 2, >= 2)
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   rx_data         received byte, valid while rx_data_ready is high
//   rx_data_ready   one-cycle byte strobe
//   rx_endofpacket  one-cycle line-idle pulse (framing resync)
//   smp             sample stream (uart_sample_packer_if.master)
//   frame_done      one-cycle pulse when a frame's byte stream completes
//   frame_error     one-cycle pulse on truncated frame / bad checksum
//   overflow        sticky: a sample was dropped on a full FIFO
//
// Optional feature: define UART_PACKER_CHECKSUM_EN to expect one extra byte
// after each frame holding the XOR of all 2*FRAME_LEN frame bytes.
module uart_sample_packer #(
  parameter int FRAME_LEN  = 256,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  rx_data,
  input  logic                        rx_data_ready,
  input  logic                        rx_endofpacket,
  uart_sample_packer_if.master        smp,
  output logic                        frame_done,
  output logic                        frame_error,
  output logic                        overflow
);

  localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
  localparam logic [AW:0]      FULL_CNT = (AW+1)'(FIFO_DEPTH);

`ifdef UART_PACKER_CHECKSUM_EN
  typedef enum logic [1:0] {S_LO, S_HI, S_CSUM} state_t;
`else
  typedef enum logic {S_LO, S_HI} state_t;
`endif

  state_t           state_q, state_d;
  logic [7:0]       lo_q, lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             frame_done_q, frame_done_d;
  logic             frame_error_q, frame_error_d;
  logic             overflow_q, overflow_d;
`ifdef UART_PACKER_CHECKSUM_EN
  logic [7:0]       csum_q, csum_d;
`endif

  // FIFO storage: {last, high byte, low byte}
  logic [16:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;

  logic             push;
  logic             push_last;
  logic             pop;
  logic             full;
  logic             wr_en;
  logic [16:0]      rd_entry;

  always_comb begin
    state_d       = state_q;
    lo_d          = lo_q;
    cnt_d         = cnt_q;
    frame_done_d  = 1'b0;
    frame_error_d = 1'b0;
    push          = 1'b0;
    push_last     = (cnt_q == LAST_IDX);
`ifdef UART_PACKER_CHECKSUM_EN
    csum_d        = csum_q;
`endif

    if (rx_data_ready) begin
      case (state_q)
        S_LO: begin
          lo_d    = rx_data;
          state_d = S_HI;
`ifdef UART_PACKER_CHECKSUM_EN
          csum_d  = csum_q ^ rx_data;
`endif
        end
        S_HI: begin
          push  = 1'b1;
          // sample count advances whether or not the FIFO accepts it
          cnt_d = push_last ? '0 : cnt_q + CNT_W'(1);
`ifdef UART_PACKER_CHECKSUM_EN
          csum_d  = csum_q ^ rx_data;
          state_d = push_last ? S_CSUM : S_LO;
`else
          frame_done_d = push_last;
          state_d      = S_LO;
`endif
        end
`ifdef UART_PACKER_CHECKSUM_EN
        S_CSUM: begin
          frame_done_d  = 1'b1;
          frame_error_d = (rx_data != csum_q);
          csum_d        = '0;
          state_d       = S_LO;
        end
`endif
        default: state_d = S_LO;
      endcase
    end

    // Resync after the coincident byte (if any) has been applied, so a
    // frame whose final byte lands with the idle pulse is not truncated.
    if (rx_endofpacket) begin
      if ((state_d != S_LO) || (cnt_d != '0)) begin
        frame_error_d = 1'b1;
      end
      state_d = S_LO;
      cnt_d   = '0;
`ifdef UART_PACKER_CHECKSUM_EN
      csum_d  = '0;
`endif
    end

    // FIFO control. A pop frees the slot in the same cycle, so a push into
    // a full FIFO succeeds when it coincides with a pop.
    pop        = (count_q != '0) && smp.sample_ready;
    full       = (count_q == FULL_CNT);
    wr_en      = push && (!full || pop);
    overflow_d = overflow_q | (push && full && !pop);
    wr_ptr_d   = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop   ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_LO;
      lo_q          <= '0;
      cnt_q         <= '0;
      frame_done_q  <= 1'b0;
      frame_error_q <= 1'b0;
      overflow_q    <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
`ifdef UART_PACKER_CHECKSUM_EN
      csum_q        <= '0;
`endif
    end else begin
      state_q       <= state_d;
      lo_q          <= lo_d;
      cnt_q         <= cnt_d;
      frame_done_q  <= frame_done_d;
      frame_error_q <= frame_error_d;
      overflow_q    <= overflow_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
`ifdef UART_PACKER_CHECKSUM_EN
      csum_q        <= csum_d;
`endif
    end
  end

  // Storage has no reset; outputs are masked by the occupancy count instead.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= {push_last, rx_data, lo_q};
    end
  end

  assign rd_entry         = mem_q[rd_ptr_q];
  assign smp.sample_valid = (count_q != '0);
  assign smp.sample_data  = smp.sample_valid ? rd_entry[15:0] : 16'h0000;
  assign smp.sample_last  = smp.sample_valid & rd_entry[16];

  assign frame_done  = frame_done_q;
  assign frame_error = frame_error_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_uart_sample_packer.sv
// tb_uart_sample_packer -- directed self-checking bench for uart_sample_packer
// with FRAME_LEN=4, FIFO_DEPTH=4. Inputs change 1 time unit after posedge;
// stream transfers and pulse counts are recorded on the negative edge.
module tb_uart_sample_packer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_data_ready;
  logic       rx_endofpacket;
  logic       frame_done;
  logic       frame_error;
  logic       overflow;

  uart_sample_packer_if sif ();

  uart_sample_packer #(
    .FRAME_LEN  (4),
    .FIFO_DEPTH (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rx_data        (rx_data),
    .rx_data_ready  (rx_data_ready),
    .rx_endofpacket (rx_endofpacket),
    .smp            (sif),
    .frame_done     (frame_done),
    .frame_error    (frame_error),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int fd_cnt = 0;
  int fe_cnt = 0;
  logic [16:0] got_q[$];

  // Record accepted samples as {last, data} and count status pulses.
  always @(negedge clk) begin
    if (!rst) begin
      if (sif.sample_valid && sif.sample_ready)
        got_q.push_back({sif.sample_last, sif.sample_data});
      if (frame_done)  fd_cnt++;
      if (frame_error) fe_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data       = b;
    rx_data_ready = 1'b1;
    step();
    rx_data_ready = 1'b0;
    $display("byte %02h", b);
  endtask

  task automatic send_sample(input logic [15:0] s);
    send_byte(s[7:0]);
    send_byte(s[15:8]);
  endtask

  task automatic send_eop();
    rx_endofpacket = 1'b1;
    step();
    rx_endofpacket = 1'b0;
    $display("eop");
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk_stream(input string tag, input logic [16:0] exp[]);
    chk({tag, "_count"}, got_q.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      if (i < got_q.size()) chk($sformatf("%s_%0d", tag, i), {15'd0, got_q[i]}, {15'd0, exp[i]});
      else                  chk($sformatf("%s_%0d_missing", tag, i), 32'hFFFF_FFFF, {15'd0, exp[i]});
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, {31'd0, sif.sample_valid}, 32'd0);
    chk({tag, "_data"},  {16'd0, sif.sample_data},  32'd0);
    chk({tag, "_last"},  {31'd0, sif.sample_last},  32'd0);
    chk({tag, "_fd"},    {31'd0, frame_done},       32'd0);
    chk({tag, "_fe"},    {31'd0, frame_error},      32'd0);
    chk({tag, "_ovf"},   {31'd0, overflow},         32'd0);
  endtask

  int fd0, fe0;

  initial begin
    rst              = 1'b1;
    rx_data          = 8'h00;
    rx_data_ready    = 1'b0;
    rx_endofpacket   = 1'b0;
    sif.sample_ready = 1'b0;
    wait_cycles(3);
    rst = 1'b0;
    step();
    chk_idle("reset");

`ifdef UART_PACKER_CHECKSUM_EN
    // Checksum frames: XOR of 01..08 is 08.
    sif.sample_ready = 1'b1;
    got_q.delete();
    for (int i = 1; i <= 8; i++) send_byte(8'(i));
    chk("cs_no_fd_before_csum", {31'd0, frame_done}, 32'd0);
    send_byte(8'h08);
    chk("cs_good_fd", {31'd0, frame_done},  32'd1);
    chk("cs_good_fe", {31'd0, frame_error}, 32'd0);
    for (int i = 1; i <= 8; i++) send_byte(8'(i));
    send_byte(8'h00);
    chk("cs_bad_fd", {31'd0, frame_done},  32'd1);
    chk("cs_bad_fe", {31'd0, frame_error}, 32'd1);
    wait_cycles(3);
    chk("cs_samples", got_q.size(), 8);
    chk_stream("cs_stream", '{17'h0_0201, 17'h0_0403, 17'h0_0605, 17'h1_0807,
                              17'h0_0201, 17'h0_0403, 17'h0_0605, 17'h1_0807});
`else
    // Basic frame with a free-running consumer.
    sif.sample_ready = 1'b1;
    got_q.delete();
    fd0 = fd_cnt;
    send_byte(8'h34);
    send_byte(8'h12);
    chk("lat_valid", {31'd0, sif.sample_valid}, 32'd1);
    chk("lat_data",  {16'd0, sif.sample_data},  32'h1234);
    send_sample(16'h5678);
    send_sample(16'hABCD);
    send_byte(8'h01);
    chk("fd_early", {31'd0, frame_done}, 32'd0);
    send_byte(8'h80);
    chk("fd_pulse", {31'd0, frame_done}, 32'd1);
    step();
    chk("fd_clear", {31'd0, frame_done}, 32'd0);
    wait_cycles(2);
    chk_stream("frame", '{17'h0_1234, 17'h0_5678, 17'h0_ABCD, 17'h1_8001});
    chk("fd_once", fd_cnt - fd0, 1);

    // Truncated frame followed by a realigned frame.
    got_q.delete();
    fe0 = fe_cnt;
    send_sample(16'h1234);
    send_byte(8'h78);
    send_eop();
    chk("trunc_fe", {31'd0, frame_error}, 32'd1);
    send_sample(16'h2211);
    send_sample(16'h4433);
    send_sample(16'h6655);
    send_sample(16'h8877);
    chk("resync_fd", {31'd0, frame_done}, 32'd1);
    wait_cycles(2);
    chk_stream("resync", '{17'h0_1234, 17'h0_2211, 17'h0_4433, 17'h0_6655, 17'h1_8877});
    chk("trunc_fe_once", fe_cnt - fe0, 1);

    // Overflow with a stalled consumer.
    do_reset();
    sif.sample_ready = 1'b0;
    got_q.delete();
    for (int i = 0; i < 6; i++) send_sample(16'h1000 + 16'(i));
    chk("ovf_flag",  {31'd0, overflow},         32'd1);
    chk("ovf_hold",  {16'd0, sif.sample_data},  32'h1000);
    chk("ovf_valid", {31'd0, sif.sample_valid}, 32'd1);
    send_sample(16'h1006);
    send_sample(16'h1007);
    chk("ovf_fd", {31'd0, frame_done}, 32'd1);
    step();
    sif.sample_ready = 1'b1;
    wait_cycles(6);
    chk_stream("ovf_drain", '{17'h0_1000, 17'h0_1001, 17'h0_1002, 17'h1_1003});
    got_q.delete();
    for (int i = 0; i < 4; i++) send_sample(16'h1010 + 16'(i));
    wait_cycles(2);
    chk_stream("ovf_align", '{17'h0_1010, 17'h0_1011, 17'h0_1012, 17'h1_1013});

    // Push and pop together on a full FIFO.
    do_reset();
    chk("full_ovf_reset", {31'd0, overflow}, 32'd0);
    sif.sample_ready = 1'b0;
    got_q.delete();
    for (int i = 0; i < 4; i++) send_sample(16'h2000 + 16'(i));
    send_byte(8'h04);
    rx_data          = 8'h20;
    rx_data_ready    = 1'b1;
    sif.sample_ready = 1'b1;
    step();
    rx_data_ready    = 1'b0;
    sif.sample_ready = 1'b0;
    chk("full_pp_ovf",  {31'd0, overflow},        32'd0);
    chk("full_pp_head", {16'd0, sif.sample_data}, 32'h2001);
    wait_cycles(2);
    chk("full_pp_popped", got_q.size(), 1);
    sif.sample_ready = 1'b1;
    wait_cycles(6);
    chk_stream("full_pp", '{17'h0_2000, 17'h0_2001, 17'h0_2002, 17'h1_2003, 17'h0_2004});

    // Reset in the middle of a frame with a sample queued.
    do_reset();
    sif.sample_ready = 1'b0;
    got_q.delete();
    fe0 = fe_cnt;
    fd0 = fd_cnt;
    send_sample(16'h2211);
    send_byte(8'h34);
    rst = 1'b1;
    step();
    chk_idle("midrst");
    rst = 1'b0;
    sif.sample_ready = 1'b1;
    send_byte(8'h78);
    send_byte(8'h56);
    chk("midrst_data", {16'd0, sif.sample_data}, 32'h5678);
    wait_cycles(2);
    chk_stream("midrst", '{17'h0_5678});
    chk("midrst_no_fe", fe_cnt - fe0, 0);
    chk("midrst_no_fd", fd_cnt - fd0, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_sample_packer.md
UART_SAMPLE_PACKER -- requirements
Module: uart_sample_packer

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 256, meaning 16-bit samples per frame (2..65535).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning output FIFO entries (power of 2, >=2).
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 rx_data  input  8  received byte, valid only while rx_data_ready is high.
REQ-006 rx_data_ready  input  1  one-cycle byte strobe from the UART receiver.
REQ-007 rx_endofpacket  input  1  one-cycle line-idle pulse; resynchronises framing.
REQ-008 sample_data  output  16  assembled signed sample, {high byte, low byte}.
REQ-009 sample_valid  output  1  FIFO non-empty; sample_data/sample_last are valid.
REQ-010 sample_ready  input  1  consumer accepts; transfer occurs when sample_valid && sample_ready.
REQ-011 sample_last  output  1  marks the final sample of a frame.
REQ-012 frame_done  output  1  one-cycle pulse when a frame's byte stream completes.
REQ-013 frame_error  output  1  one-cycle pulse on a truncated frame (or bad checksum, see REQ-030).
REQ-014 overflow  output  1  sticky flag: a sample was dropped because the FIFO was full.

Function
REQ-015 States: S_LO (await low byte), S_HI (await high byte), S_CSUM (present only per REQ-029).
REQ-016 In S_LO, rx_data_ready SHALL latch rx_data as the low byte and move to S_HI.
REQ-017 In S_HI, rx_data_ready SHALL push {rx_data, low} plus last flag (sample_cnt==FRAME_LEN-1) into the FIFO and return to S_LO.
REQ-018 sample_cnt SHALL be FRAME_LEN-wide-enough, increment per pushed-or-dropped sample, and wrap to 0 after FRAME_LEN-1.
REQ-019 Latency: a sample SHALL be visible with sample_valid high on the cycle after its high-byte strobe, if the FIFO was empty.
REQ-020 frame_done SHALL pulse on the cycle after the high-byte strobe of sample FRAME_LEN-1.
REQ-021 sample_data/sample_last SHALL hold stable while sample_valid && !sample_ready; FIFO is first-word-fall-through.
REQ-022 A push and a pop in the same cycle on a full FIFO SHALL both succeed (no drop).
REQ-023 A push on a full FIFO without a simultaneous pop SHALL drop the sample, set overflow, and still advance sample_cnt.
REQ-024 rx_endofpacket SHALL reset the state to S_LO and sample_cnt to 0, discarding any latched low byte.
REQ-025 If rx_endofpacket arrives with state!=S_LO or sample_cnt!=0, frame_error SHALL pulse on the next cycle; FIFO contents are kept.
REQ-026 If rx_data_ready and rx_endofpacket coincide, the byte SHALL be processed first, then resync applied.

Reset
REQ-027 rst SHALL empty the FIFO and set state=S_LO, sample_cnt=0, sample_valid=0, sample_last=0, sample_data=0, frame_done=0, frame_error=0, overflow=0.
REQ-028 rst asserted mid-frame SHALL abandon the frame with no frame_done or frame_error pulse.

Configuration
REQ-029 With macro UART_PACKER_CHECKSUM_EN defined, after sample FRAME_LEN-1 state SHALL go to S_CSUM, and the next byte SHALL be compared to the XOR of all 2*FRAME_LEN frame bytes.
REQ-030 With UART_PACKER_CHECKSUM_EN, frame_done SHALL pulse on the cycle after the checksum byte, with frame_error pulsing in the same cycle on mismatch; rx_endofpacket in S_CSUM counts as truncation per REQ-025.
REQ-031 Without UART_PACKER_CHECKSUM_EN, S_CSUM and XOR logic SHALL be absent and REQ-020 applies.

Verification (FRAME_LEN=4, FIFO_DEPTH=4, macro undefined unless stated)
REQ-032 Bytes 34 12 78 56 CD AB 01 80, sample_ready=1 -> samples 0x1234, 0x5678, 0xABCD, 0x8001; sample_last only on 0x8001; one frame_done.
REQ-033 Bytes 34 12 78, then rx_endofpacket -> one sample 0x1234, frame_error pulse; next bytes 11 22 yield 0x2211 with sample_cnt restarted at 0.
REQ-034 sample_ready=0, 6 samples sent -> first 4 held in order, overflow=1, sample_cnt still wraps so next frame aligns.
REQ-035 FIFO full, push and pop same cycle -> no drop, overflow stays 0, occupancy stays 4.
REQ-036 Macro defined, bytes 01 02 03 04 05 06 07 08 then 08 -> frame_done, no frame_error; checksum byte 00 -> frame_done with frame_error.
REQ-037 rst asserted after byte 34 -> all outputs at reset values next cycle; following bytes 78 56 yield 0x5678.
